// File: rtl/canvas_arb_pkg.sv
// Shared constants and types for the canvas RAM arbiter.
package canvas_arb_pkg;

  localparam int unsigned DEF_ADDR_W     = 15;
  localparam int unsigned DEF_DATA_W     = 3;
  localparam int unsigned DEF_N_REQ      = 3;
  localparam int unsigned DEF_RD_LATENCY = 2;

  // Requester slots on the arbiter ports
  localparam int unsigned REQ_CLEAR = 0;
  localparam int unsigned REQ_DRAW  = 1;
  localparam int unsigned REQ_SAVE  = 2;

  localparam int unsigned REQ_ID_W = $clog2(DEF_N_REQ);

  // One slot of the read-return pipeline
  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/arb_pick.sv
// One-hot picker: first set request at or after start, wrapping past N-1.
module arb_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot;
  logic [N-1:0]   first;

  // Rotate so start sits at bit 0, take lowest set bit, rotate back
  always_comb begin
    dbl   = {req, req} >> start;
    first = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        first    = '0;
        first[i] = 1'b1;
      end
    end
    rot = {{N{1'b0}}, first} << start;
    gnt = rot[N-1:0] | rot[2*N-1:N];
  end

endmodule

// File: rtl/canvas_ram_arbiter.sv
// Arbitrates the single-port canvas RAM between clear, draw and save
// requesters, issues registered commands and routes read data back.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority
// (lowest index wins).
module canvas_ram_arbiter
  import canvas_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned N_REQ      = DEF_N_REQ,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic [N_REQ-1:0]         iReq,
  input  logic [N_REQ-1:0]         iWe,
  input  logic [N_REQ-1:0]         iLock,
  input  logic [N_REQ*ADDR_W-1:0]  iAddr,
  input  logic [N_REQ*DATA_W-1:0]  iData,
  output logic [N_REQ-1:0]         oGnt,
  output logic [N_REQ-1:0]         oRdValid,
  output logic [DATA_W-1:0]        oRdData,
  output logic [ADDR_W-1:0]        oAddress,
  output logic [DATA_W-1:0]        oData,
  output logic                     oWren,
  output logic                     oChipSelect,
  input  logic [DATA_W-1:0]        iQ,
  output logic                     oBusy
);

  // Requester ids are sized for the package default requester count
  localparam int unsigned ID_W = REQ_ID_W;

  logic              prev_valid;
  logic [ID_W-1:0]   prev_id;
  logic [N_REQ-1:0]  prev_onehot;
  logic              lock_hit;
  logic [N_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]   pick_start;
  logic              transfer;
  logic [ID_W-1:0]   gnt_id;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  rd_tag_t           cmd_tag;
  rd_tag_t           rd_pipe [RD_LATENCY];
  logic              busy_next;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  // Search pointer moves to the slot after each granted requester
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      rr_ptr <= ID_W'(REQ_CLEAR);
    end else if (transfer) begin
      rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  assign pick_start = rr_ptr;
`else
  assign pick_start = '0;
`endif

  arb_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (iReq),
    .start (pick_start),
    .gnt   (pick_gnt)
  );

  // A held lock from last cycle's winner overrides normal arbitration
  assign prev_onehot = N_REQ'(1) << prev_id;
  assign lock_hit    = prev_valid && |(prev_onehot & iReq & iLock);
  assign oGnt        = lock_hit ? prev_onehot : pick_gnt;
  assign transfer    = |oGnt;

  // Encode the winner and select its command fields
  always_comb begin
    gnt_id   = '0;
    sel_we   = 1'b0;
    sel_lock = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (oGnt[k]) begin
        gnt_id   = ID_W'(k);
        sel_we   = iWe[k];
        sel_lock = iLock[k];
        sel_addr = iAddr[k*ADDR_W +: ADDR_W];
        sel_data = iData[k*DATA_W +: DATA_W];
      end
    end
  end

  // Command register toward the memory controller; address/data hold when idle
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      oChipSelect <= 1'b0;
      oWren       <= 1'b0;
      oAddress    <= '0;
      oData       <= '0;
      prev_valid  <= 1'b0;
      prev_id     <= '0;
      cmd_tag     <= '0;
    end else begin
      oChipSelect   <= transfer;
      oWren         <= transfer && sel_we;
      prev_valid    <= transfer;
      cmd_tag.valid <= transfer && !sel_we;
      cmd_tag.id    <= gnt_id;
      if (transfer) begin
        oAddress <= sel_addr;
        oData    <= sel_data;
        prev_id  <= gnt_id;
      end
    end
  end

  // Busy for the next cycle: any read still heading back, or a lock carried over
  always_comb begin
    busy_next = (transfer && !sel_we) || (transfer && sel_lock) || cmd_tag.valid;
    for (int unsigned s = 0; s + 1 < RD_LATENCY; s++) begin
      busy_next = busy_next || rd_pipe[s].valid;
    end
  end

  // Read-return pipeline: last stage lines up with iQ for its command
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      for (int unsigned s = 0; s < RD_LATENCY; s++) begin
        rd_pipe[s] <= '0;
      end
      oRdValid <= '0;
      oRdData  <= '0;
      oBusy    <= 1'b0;
    end else begin
      rd_pipe[0] <= cmd_tag;
      for (int unsigned s = 1; s < RD_LATENCY; s++) begin
        rd_pipe[s] <= rd_pipe[s-1];
      end
      oRdValid <= rd_pipe[RD_LATENCY-1].valid ? (N_REQ'(1) << rd_pipe[RD_LATENCY-1].id) : '0;
      if (rd_pipe[RD_LATENCY-1].valid) begin
        oRdData <= iQ;
      end
      oBusy <= busy_next;
    end
  end

endmodule
